// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM state encoding and ACK/NACK bit levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_slv_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Per-line conditioning for SCL/SDA: synchronizer, optional counter glitch filter
// (GLITCH_FILTER_EN), and rise/fall detection on the conditioned level.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   synced;
    logic                   level;
    logic                   prev_q, prev_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    assign synced = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Down-counter reloads whenever the raw value agrees; flips the output on terminal count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = CW'(FILT_LEN);
        if (synced != filt_q) begin
            if (cnt_q == CW'(1)) filt_d = synced;
            else                 cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= CW'(FILT_LEN);
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = synced;
`endif

    always_comb prev_d = level;

    // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~prev_q;
    assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// Byte-level I2C target with open-drain SDA. Optional SCL/SDA glitch filter via GLITCH_FILTER_EN.
// state        | meaning
// IDLE         | bus free or not yet started
// ADDR         | shifting in address + R/W
// ADDR_ACK     | driving address ACK
// WR_DATA      | shifting in a write byte
// WR_ACK       | ACK/NACK slot for a write byte
// RD_DATA      | shifting out a read byte
// RD_ACK       | sampling master ACK/NACK
// WAIT_STOP    | ignoring bus until START/STOP
import i2c_pkg::*;

module i2c_slave #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic       ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       addr_hit,
    output logic       rw,
    output logic       busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_c, stop_c, load_tx;

    i2c_slv_state_e state_q, state_d;
    logic [7:0]     shift_q, shift_d, rx_data_q, rx_data_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           sda_low_q, sda_low_d, rw_q, rw_d, hit_q, hit_d, busy_q, busy_d;
    logic           rx_done_q, rx_done_d, tx_load_q, tx_load_d, ack_q, ack_d;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk), .rst_n(reset), .line_i(SCL),
        .level_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk), .rst_n(reset), .line_i(SDA),
        .level_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    assign start_c = sda_fall & scl;
    assign stop_c  = sda_rise & scl;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        sda_low_d = sda_low_q;
        rw_d      = rw_q;
        hit_d     = hit_q;
        busy_d    = busy_q;
        rx_data_d = rx_data_q;
        ack_d     = ack_q;
        rx_done_d = 1'b0;
        tx_load_d = 1'b0;
        load_tx   = 1'b0;
        if (start_c) begin
            state_d   = ST_ADDR;
            cnt_d     = 4'd8;
            busy_d    = 1'b1;
            hit_d     = 1'b0;
            sda_low_d = 1'b0;
        end else if (stop_c) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            hit_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && cnt_q != 4'd0) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q - 4'd1;
                    end else if (scl_fall && cnt_q == 4'd0) begin
                        if (shift_q[7:1] == SLV_ADDR) begin
                            sda_low_d = 1'b1;
                            rw_d      = shift_q[0];
                            hit_d     = 1'b1;
                            state_d   = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            cnt_d     = 4'd8;
                            state_d   = ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd0) begin
                        shift_d = {shift_q[6:0], sda};
                        cnt_d   = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            rx_data_d = {shift_q[6:0], sda};
                            rx_done_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd0) begin
                        sda_low_d = ack_en;
                        ack_d     = ack_en ? I2C_ACK : I2C_NACK;
                        state_d   = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        if (ack_q == I2C_ACK) begin
                            cnt_d   = 4'd8;
                            state_d = ST_WR_DATA;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            sda_low_d = 1'b0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                            cnt_d     = cnt_q - 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda;
                    end else if (scl_fall) begin
                        if (ack_q == I2C_ACK) load_tx = 1'b1;
                        else                  state_d = ST_WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
        // cnt counts bits still to be shifted after the one now on the wire.
        if (load_tx) begin
            shift_d   = tx_data;
            tx_load_d = 1'b1;
            sda_low_d = ~tx_data[7];
            cnt_d     = 4'd7;
            state_d   = ST_RD_DATA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            cnt_q     <= 4'd0;
            sda_low_q <= 1'b0;
            rw_q      <= 1'b0;
            hit_q     <= 1'b0;
            busy_q    <= 1'b0;
            rx_data_q <= 8'h00;
            ack_q     <= I2C_NACK;
            rx_done_q <= 1'b0;
            tx_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            sda_low_q <= sda_low_d;
            rw_q      <= rw_d;
            hit_q     <= hit_d;
            busy_q    <= busy_d;
            rx_data_q <= rx_data_d;
            ack_q     <= ack_d;
            rx_done_q <= rx_done_d;
            tx_load_q <= tx_load_d;
        end
    end

    assign SDA      = sda_low_q ? 1'b0 : 1'bz;
    assign tx_load  = tx_load_q;
    assign rx_data  = rx_data_q;
    assign rx_done  = rx_done_q;
    assign addr_hit = hit_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C master, transaction-level model, per-cycle compare process.
module tb_i2c_slave;

    localparam int Q      = 16;
    localparam int SETTLE = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       ack_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load, rx_done, addr_hit, rw, busy;
    logic [7:0] rx_data;
    wire        sda_bus;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave #(.SLV_ADDR(7'h50)) dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus), .ack_en(ack_en),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data), .rx_done(rx_done),
        .addr_hit(addr_hit), .rw(rw), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic       exp_busy = 1'b0, exp_hit = 1'b0, exp_rw = 1'b0;
    logic [7:0] exp_last = 8'h00;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_vals[$];
    int         tx_idx = 0, rd_ptr = 0;
    logic       cur_hit = 1'b0, cur_rw = 1'b0, listen = 1'b0;
    logic       pend_valid = 1'b0, pend_hit = 1'b0, pend_rw = 1'b0;
    logic       glitch = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One SCL period; the pending model update lands on the falling edge that causes it.
    task automatic m_bit(input logic b, output logic r);
        m_sda_low = ~b;
        wq(Q);
        scl = 1'b1;
        if (glitch) begin
            wq(4); scl = 1'b0; wq(2); scl = 1'b1; wq(Q - 6);
        end else begin
            wq(Q);
        end
        r = sda_bus;
        wq(Q);
        scl = 1'b0;
        if (pend_valid) begin
            exp_hit = pend_hit;
            if (pend_hit) exp_rw = pend_rw;
            pend_valid = 1'b0;
        end
        wq(Q);
    endtask

    task automatic m_start();
        if (scl == 1'b0) begin
            m_sda_low = 1'b0; wq(Q); scl = 1'b1; wq(Q);
        end
        m_sda_low = 1'b1;
        exp_busy = 1'b1;
        exp_hit = 1'b0;
        wq(Q);
        scl = 1'b0;
        wq(Q);
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; wq(Q);
        scl = 1'b1; wq(Q);
        m_sda_low = 1'b0;
        exp_busy = 1'b0;
        exp_hit = 1'b0;
        listen = 1'b0;
        wq(2 * Q);
    endtask

    task automatic m_addr(input logic [6:0] a, input logic rwb);
        logic [7:0] byt;
        logic       r;
        byt = {a, rwb};
        m_start();
        cur_hit = (a == 7'h50);
        listen = cur_hit;
        if (cur_hit) cur_rw = rwb;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                pend_valid = 1'b1; pend_hit = cur_hit; pend_rw = rwb;
            end
            m_bit(byt[i], r);
        end
        m_bit(1'b1, r);
        chk("addr_ack_slot", r, cur_hit ? 0 : 1);
    endtask

    task automatic m_wr(input logic [7:0] d, input int gbit);
        logic r, ack_low;
        ack_low = listen && !cur_rw && ack_en;
        if (listen && !cur_rw) exp_rx.push_back(d);
        for (int i = 7; i >= 0; i--) begin
            glitch = (i == gbit);
            m_bit(d[i], r);
            glitch = 1'b0;
        end
        m_bit(1'b1, r);
        chk("wr_ack_slot", r, ack_low ? 0 : 1);
        if (!ack_low) listen = 1'b0;
    endtask

    task automatic m_rd(input logic mack, output logic [7:0] d);
        logic       r;
        logic [7:0] e;
        e = 8'hFF;
        if (listen && cur_rw) begin
            e = tx_vals[rd_ptr];
            rd_ptr++;
        end
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
        end
        chk("rd_byte", d, e);
        m_bit(mack ? 1'b0 : 1'b1, r);
        if (!mack) listen = 1'b0;
    endtask

    // Compare process: pulses every cycle, levels once lines have been quiet long enough.
    initial begin
        int   settle;
        logic p_scl, p_sda, p_rst;
        settle = 0; p_scl = 1'b1; p_sda = 1'b0; p_rst = 1'b0;
        forever begin
            @(negedge clk);
            if (scl !== p_scl || m_sda_low !== p_sda || reset !== p_rst) settle = 0;
            else if (settle < 100000) settle++;
            p_scl = scl; p_sda = m_sda_low; p_rst = reset;
            if (rx_done === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_done_unexpected actual=1 required=0 rx_data=%0h", rx_data);
                end else begin
                    exp_last = exp_rx.pop_front();
                    chk("rx_data_at_done", rx_data, exp_last);
                end
            end
            if (tx_load === 1'b1) begin
                tx_idx++;
                tx_data = (tx_idx < tx_vals.size()) ? tx_vals[tx_idx] : 8'h00;
            end
            if (settle >= SETTLE) begin
                chk("busy", busy, exp_busy);
                chk("addr_hit", addr_hit, exp_hit);
                chk("rw", rw, exp_rw);
                chk("rx_data_hold", rx_data, exp_last);
            end
        end
    end

    initial begin
        logic [7:0] d0, d1, b6;
        logic       r;
        wq(5);
        chk("rst_busy", busy, 0);
        chk("rst_addr_hit", addr_hit, 0);
        chk("rst_rw", rw, 0);
        chk("rst_rx_done", rx_done, 0);
        chk("rst_tx_load", tx_load, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_sda", sda_bus, 1);
        reset = 1'b1;
        wq(2 * Q);

        m_addr(7'h50, 1'b0);
        m_wr(8'hA5, -1);
        m_wr(8'h3C, -1);
        chk("wr_rx_lit", rx_data, 8'h3C);
        m_stop();
        chk("wr_busy_after_stop", busy, 0);

        tx_vals.push_back(8'hC3);
        tx_vals.push_back(8'h7E);
        tx_data = tx_vals[tx_idx];
        m_addr(7'h50, 1'b1);
        m_rd(1'b1, d0);
        m_rd(1'b0, d1);
        chk("rd_lit0", d0, 8'hC3);
        chk("rd_lit1", d1, 8'h7E);
        wq(2 * Q);
        chk("rd_nack_released", sda_bus, 1);
        m_stop();
        chk("rd_tx_load_cnt", tx_idx, 2);

        m_addr(7'h51, 1'b0);
        m_wr(8'h12, -1);
        chk("miss_addr_hit", addr_hit, 0);
        chk("miss_busy", busy, 1);
        m_stop();

        tx_vals.push_back(8'h99);
        tx_data = tx_vals[tx_idx];
        m_addr(7'h50, 1'b0);
        m_wr(8'h10, -1);
        chk("rpt_rx_lit", rx_data, 8'h10);
        chk("rpt_rw_wr", rw, 0);
        m_addr(7'h50, 1'b1);
        chk("rpt_rw_rd", rw, 1);
        m_rd(1'b0, d0);
        chk("rpt_rd_lit", d0, 8'h99);
        m_stop();
        chk("rpt_tx_load_cnt", tx_idx, 3);

        ack_en = 1'b0;
        m_addr(7'h50, 1'b0);
        m_wr(8'h77, -1);
        m_wr(8'h88, -1);
        ack_en = 1'b1;
        m_addr(7'h50, 1'b0);
        m_wr(8'h42, -1);
        m_stop();
        chk("nack_then_start_rx_lit", rx_data, 8'h42);

        b6 = 8'hA0;
        m_start();
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                pend_valid = 1'b1; pend_hit = 1'b1; pend_rw = 1'b0;
            end
            m_bit(b6[i], r);
        end
        m_sda_low = 1'b0;
        wq(4);
        chk("ack_driven_before_rst", sda_bus, 0);
        exp_busy = 1'b0; exp_hit = 1'b0; exp_rw = 1'b0; exp_last = 8'h00; listen = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_sda_released", sda_bus, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr_hit", addr_hit, 0);
        chk("midrst_rx_data", rx_data, 8'h00);
        chk("midrst_rx_done", rx_done, 0);
        chk("midrst_tx_load", tx_load, 0);
        chk("midrst_rw", rw, 0);
        wq(4);
        reset = 1'b1;
        scl = 1'b1;
        wq(2 * Q);
        m_addr(7'h50, 1'b0);
        m_wr(8'h5A, -1);
        m_stop();
        chk("post_rst_rx_lit", rx_data, 8'h5A);

`ifdef GLITCH_FILTER_EN
        m_addr(7'h50, 1'b0);
        m_wr(8'hB4, 4);
        m_stop();
        chk("glitch_rx_lit", rx_data, 8'hB4);
`endif

        wq(10);
        chk("rx_queue_drained", exp_rx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
